sha1_sequencer: RTL and testbench
=================================

// Module: sha1_sequencer
// PURPOSE
//  Top-level control FSM for the SHA1 core. On start it drives the 2-bit phase code to the
//  initial-state block and samples the padding_length that block returns.
//  It then computes the 512-bit block count and steps the round datapath through 80 rounds
//  per block, with per-block hash update strobes. It sits above the initial-state, message
//  schedule and round/compression blocks and is the only source of the phase code.
// PARAMETERS
//  NUM_ROUNDS  80  rounds per 512-bit block
//  NUM_WORDS   16  rounds that load message words directly (w_load window)
//  BLK_W       26  width of block counter (32-bit byte total >> 6)
// PORTS
//  clk            in   1      system clock, all state on rising edge
//  reset          in   1      asynchronous, active-high reset
//  start          in   1      request to hash; sampled only in IDLE
//  message_size   in   32     message length in bytes; sampled with start
//  padding_length in   32     pad bytes from initial-state block; sampled in PADWAIT
//  input_state    out  2      phase code: 00 IDLE, 01 INIT/PADWAIT, 10 ROUNDS/UPDATE, 11 DONE
//  hash_init      out  1      1-cycle strobe in INIT: load H0..H4 constants
//  round_en       out  1      high every ROUNDS cycle
//  round_idx      out  7      current round 0..NUM_ROUNDS-1, valid while round_en
//  w_load         out  1      round_en && round_idx < NUM_WORDS
//  block_index    out  BLK_W  block being processed, 0-based
//  hash_update    out  1      1-cycle strobe in UPDATE: H += a..e
//  busy           out  1      high in INIT, PADWAIT, ROUNDS, UPDATE
//  done           out  1      1-cycle pulse in DONE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, input_state=00, all strobes/busy/done=0,
//   round_idx=0, block_index=0, latched size/count regs=0. All outputs registered.
//  FSM: IDLE -(start)-> INIT -> PADWAIT -> ROUNDS -> UPDATE -> {ROUNDS | DONE} -> IDLE.
//  IDLE: start=1 latches message_size; next state INIT. start=0 holds.
//  INIT (1 cycle): input_state=01, hash_init=1; initial-state block registers pad length.
//  PADWAIT (1 cycle): input_state=01; latch num_blocks = (message_size+padding_length)>>6,
//   33-bit sum, truncated to BLK_W; num_blocks==0 forced to 1. block_index=0, round_idx=0.
//  ROUNDS: input_state=10, round_en=1; round_idx increments each cycle; after round_idx==79
//   go to UPDATE with round_idx cleared to 0.
//  UPDATE (1 cycle): hash_update=1; if block_index==num_blocks-1 -> DONE, else
//   block_index+1 and -> ROUNDS.
//  DONE (1 cycle): input_state=11, done=1, busy=0; -> IDLE (block_index held until next start).
//  start while not IDLE is ignored (no queueing); message_size changes after capture ignored.
//  Latency, start sampled at edge 0: INIT cyc1, PADWAIT cyc2, ROUNDS cyc3..82, UPDATE 83,
//   DONE 84. Each extra block adds 81 cycles (80 rounds + UPDATE).
//  start asserted in the DONE cycle is ignored; start asserted in the following IDLE cycle
//   is accepted. busy and done are never high together.
// TESTING
//  T1 reset: assert reset mid-cycle -> all outputs 0 asynchronously, input_state=00, stays IDLE.
//  T2 one block: size=0, pad=64, start 1 cycle -> hash_init @1, round_en @3..82 with w_load
//   @3..18, hash_update @83, done @84, block_index=0.
//  T3 two blocks: size=64, pad=64 -> hash_update @83 and @164, block_index 0 then 1, done @165.
//  T4 zero count: size=0, pad=0 -> num_blocks forced to 1, done @84.
//  T5 start held/retriggered while busy -> single run only, done @84, no second hash_init.
//  T6 reset at round_idx=40 of block 1 -> IDLE immediately; new start gives T2 timing exactly.

Source files
------------

// File: rtl/sha1_sequencer.sv
// ---------------------------------------------------------------------------
// sha1_sequencer
// Top-level control FSM for the SHA1 core. On start it asks the initial-state
// block for the pad length (phase code 01), derives the 512-bit block count,
// then steps the round datapath through NUM_ROUNDS rounds per block with a
// hash-update strobe after each block, and finally pulses done.
//
// Ports
//   clk            in   system clock, all state on rising edge
//   reset          in   asynchronous active-high reset
//   start          in   hash request, sampled only in IDLE
//   message_size   in   message length in bytes, captured with start
//   padding_length in   pad bytes from the initial-state block, sampled in PADWAIT
//   input_state    out  phase code: 00 IDLE, 01 INIT/PADWAIT, 10 ROUNDS/UPDATE, 11 DONE
//   hash_init      out  1-cycle strobe in INIT (load H0..H4)
//   round_en       out  high on every ROUNDS cycle
//   round_idx      out  current round, valid while round_en
//   w_load         out  round_en during the first NUM_WORDS rounds
//   block_index    out  0-based index of the block being processed
//   hash_update    out  1-cycle strobe in UPDATE (H += a..e)
//   busy           out  high in INIT, PADWAIT, ROUNDS, UPDATE
//   done           out  1-cycle pulse in DONE
// ---------------------------------------------------------------------------
module sha1_sequencer #(
    parameter int NUM_ROUNDS = 80,
    parameter int NUM_WORDS  = 16,
    parameter int BLK_W      = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      message_size,
    input  logic [31:0]      padding_length,
    output logic [1:0]       input_state,
    output logic             hash_init,
    output logic             round_en,
    output logic [6:0]       round_idx,
    output logic             w_load,
    output logic [BLK_W-1:0] block_index,
    output logic             hash_update,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_PAD    = 3'd2;
    localparam logic [2:0] S_ROUNDS = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [31:0]      size_q, size_d;
    logic [BLK_W-1:0] nblk_q, nblk_d;
    logic [6:0]       round_q, round_d;
    logic [BLK_W-1:0] blk_q, blk_d;

    logic [1:0]       input_state_q, input_state_d;
    logic             hash_init_q, hash_init_d;
    logic             round_en_q, round_en_d;
    logic             w_load_q, w_load_d;
    logic             hash_update_q, hash_update_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Byte total is a 33-bit sum so a carry out of 32 bits is not lost before
    // the >>6; the count is then truncated to BLK_W bits.
    logic [32:0]      byte_total;
    logic [BLK_W-1:0] nblk_calc;

    assign byte_total = {1'b0, size_q} + {1'b0, padding_length};
    assign nblk_calc  = BLK_W'(byte_total >> 6);

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        nblk_d  = nblk_q;
        round_d = round_q;
        blk_d   = blk_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                    size_d  = message_size;
                    blk_d   = '0;
                end
            end
            S_INIT: state_d = S_PAD;
            S_PAD: begin
                // An empty message still produces one (all-padding) block.
                nblk_d  = (nblk_calc == '0) ? BLK_W'(1) : nblk_calc;
                round_d = '0;
                blk_d   = '0;
                state_d = S_ROUNDS;
            end
            S_ROUNDS: begin
                if (round_q == 7'(NUM_ROUNDS - 1)) begin
                    round_d = '0;
                    state_d = S_UPDATE;
                end else begin
                    round_d = round_q + 7'd1;
                end
            end
            S_UPDATE: begin
                if (blk_q == nblk_q - BLK_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    blk_d   = blk_q + BLK_W'(1);
                    state_d = S_ROUNDS;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so every output
    // lines up with the state it describes without combinational paths.
    always_comb begin
        input_state_d = 2'b00;
        hash_init_d   = 1'b0;
        hash_update_d = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        case (state_d)
            S_INIT:   begin input_state_d = 2'b01; hash_init_d = 1'b1; busy_d = 1'b1; end
            S_PAD:    begin input_state_d = 2'b01; busy_d = 1'b1; end
            S_ROUNDS: begin input_state_d = 2'b10; busy_d = 1'b1; end
            S_UPDATE: begin input_state_d = 2'b10; hash_update_d = 1'b1; busy_d = 1'b1; end
            S_DONE:   begin input_state_d = 2'b11; done_d = 1'b1; end
            default:  input_state_d = 2'b00;
        endcase
        round_en_d = (state_d == S_ROUNDS);
        w_load_d   = round_en_d && (round_d < 7'(NUM_WORDS));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            size_q        <= '0;
            nblk_q        <= '0;
            round_q       <= '0;
            blk_q         <= '0;
            input_state_q <= 2'b00;
            hash_init_q   <= 1'b0;
            round_en_q    <= 1'b0;
            w_load_q      <= 1'b0;
            hash_update_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            size_q        <= size_d;
            nblk_q        <= nblk_d;
            round_q       <= round_d;
            blk_q         <= blk_d;
            input_state_q <= input_state_d;
            hash_init_q   <= hash_init_d;
            round_en_q    <= round_en_d;
            w_load_q      <= w_load_d;
            hash_update_q <= hash_update_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign input_state = input_state_q;
    assign hash_init   = hash_init_q;
    assign round_en    = round_en_q;
    assign round_idx   = round_q;
    assign w_load      = w_load_q;
    assign block_index = blk_q;
    assign hash_update = hash_update_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_sha1_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sha1_sequencer
// Self-checking bench for sha1_sequencer. Each run is compared cycle by cycle
// against a timeline model: given the byte total it derives the block count
// and, from the cycle number after start, which phase the core must be in.
// ---------------------------------------------------------------------------
module tb_sha1_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] message_size;
    logic [31:0] padding_length;
    logic [1:0]  input_state;
    logic        hash_init;
    logic        round_en;
    logic [6:0]  round_idx;
    logic        w_load;
    logic [25:0] block_index;
    logic        hash_update;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic [25:0] prev_blk = '0;

    always #5 clk = ~clk;

    sha1_sequencer #(.NUM_ROUNDS(80), .NUM_WORDS(16), .BLK_W(26)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .message_size   (message_size),
        .padding_length (padding_length),
        .input_state    (input_state),
        .hash_init      (hash_init),
        .round_en       (round_en),
        .round_idx      (round_idx),
        .w_load         (w_load),
        .block_index    (block_index),
        .hash_update    (hash_update),
        .busy           (busy),
        .done           (done)
    );

    // {input_state, hash_init, round_en, round_idx, w_load, block_index, hash_update, busy, done}
    logic [40:0] obs;
    assign obs = {input_state, hash_init, round_en, round_idx, w_load,
                  block_index, hash_update, busy, done};

    task automatic chk(input string tag, input logic [40:0] got, input logic [40:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int blocks_for(input logic [31:0] sz, input logic [31:0] pd);
        longint total;
        longint nb;
        total = longint'(sz) + longint'(pd);
        nb    = (total / 64) % (longint'(1) << 26);
        if (nb == 0) nb = 1;
        return int'(nb);
    endfunction

    // Expected outputs t cycles after start was sampled (t=0: idle).
    function automatic logic [40:0] model(input int t, input int nb, input logic [25:0] pb);
        logic [1:0]  st;
        logic        hi, re, wl, hu, bz, dn;
        logic [6:0]  ri;
        logic [25:0] bi;
        int k;
        st = 2'b00; hi = 0; re = 0; wl = 0; hu = 0; bz = 0; dn = 0; ri = '0; bi = pb;
        if (t == 1 || t == 2) begin
            st = 2'b01; hi = (t == 1); bz = 1; bi = '0;
        end else if (t >= 3 && t < 3 + 81 * nb) begin
            k  = t - 3;
            st = 2'b10; bz = 1; bi = 26'(k / 81);
            if (k % 81 < 80) begin
                re = 1; ri = 7'(k % 81); wl = (k % 81) < 16;
            end else begin
                hu = 1;
            end
        end else if (t == 3 + 81 * nb) begin
            st = 2'b11; dn = 1; bi = 26'(nb - 1);
        end else if (t > 3 + 81 * nb) begin
            bi = 26'(nb - 1);
        end
        return {st, hi, re, ri, wl, bi, hu, bz, dn};
    endfunction

    // Called at a negedge; start is presented for the following rising edge.
    task automatic run(input logic [31:0] sz, input logic [31:0] pd,
                       input bit retrig, input int abort_t);
        int nb;
        int tend;
        nb   = blocks_for(sz, pd);
        tend = 3 + 81 * nb;
        start          = 1'b1;
        message_size   = sz;
        padding_length = pd;
        for (int t = 1; t <= tend + 1; t++) begin
            @(negedge clk);
            chk($sformatf("run sz=%0d pd=%0d t=%0d", sz, pd, t), obs, model(t, nb, prev_blk));
            if (t == abort_t) begin
                reset = 1'b1;
                #1;
                chk("async_reset", obs, 41'd0);
                @(negedge clk);
                chk("reset_hold", obs, 41'd0);
                reset    = 1'b0;
                start    = 1'b0;
                prev_blk = '0;
                return;
            end
            start = retrig ? 1'($urandom_range(0, 1)) : 1'b0;
            if (retrig) message_size = $urandom;
            if (t == tend) start = 1'b1;       // ignored in the DONE cycle
            if (t == tend + 1) start = 1'b0;
        end
        prev_blk = 26'(nb - 1);
    endtask

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        message_size   = '0;
        padding_length = '0;
        repeat (2) @(negedge clk);
        chk("reset_state", obs, 41'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("idle_after_reset%0d", i), obs, model(0, 1, '0));
        end

        run(32'd0,  32'd64, 1'b0, -1);              // one block
        run(32'd64, 32'd64, 1'b0, -1);              // two blocks
        run(32'd0,  32'd0,  1'b0, -1);              // count forced to 1
        run(32'd0,  32'd64, 1'b1, -1);              // start re-asserted while busy
        run(32'd64, 32'd64, 1'b0, 3 + 81 + 40);     // reset at round 40 of block 1
        run(32'd0,  32'd64, 1'b0, -1);              // clean run after abort
        run(32'hFFFF_FFC0, 32'd64, 1'b0, -1);       // 33-bit carry truncates to 0 -> 1 block
        for (int i = 0; i < 6; i++) begin
            run($urandom_range(0, 200), $urandom_range(0, 100), 1'($urandom_range(0, 1)), -1);
        end

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("final_idle%0d", i), obs, model(0, 1, prev_blk));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
